// File: rtl/morse_encoder.sv
// Morse code keyer: turns a 6-bit character code into timed key_out marks.
// Dots, dashes and gaps are whole multiples of UNIT_CYCLES clocks.
module morse_encoder #(
  parameter int UNIT_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       start,
  input  logic [5:0] char_code,
  output logic       key_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CW = $clog2(7 * UNIT_CYCLES);

  localparam logic [CW-1:0] T1 = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] T3 = CW'(3 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] T7 = CW'(7 * UNIT_CYCLES - 1);

  localparam logic [5:0] CODE_MAX = 6'd35;
  localparam logic [5:0] CODE_WS  = 6'd36;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_GAP,
    S_CHAR_GAP,
    S_WORD_GAP
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [2:0]      r_len;
  logic [4:0]      r_pat;
  logic            r_key;
  logic            r_busy;
  logic            r_done;
  logic            r_err;

  logic [7:0]      w_rom;
  logic            w_dash;
  logic            w_last;
  logic            w_mark_end;

  // Entry is {element count, pattern}; the first element sits in bit 4.
  function automatic logic [7:0] rom(input logic [5:0] c);
    logic [7:0] v;
    case (c)
      6'd0:  v = {3'd2, 5'b01000};
      6'd1:  v = {3'd4, 5'b10000};
      6'd2:  v = {3'd4, 5'b10100};
      6'd3:  v = {3'd3, 5'b10000};
      6'd4:  v = {3'd1, 5'b00000};
      6'd5:  v = {3'd4, 5'b00100};
      6'd6:  v = {3'd3, 5'b11000};
      6'd7:  v = {3'd4, 5'b00000};
      6'd8:  v = {3'd2, 5'b00000};
      6'd9:  v = {3'd4, 5'b01110};
      6'd10: v = {3'd3, 5'b10100};
      6'd11: v = {3'd4, 5'b01000};
      6'd12: v = {3'd2, 5'b11000};
      6'd13: v = {3'd2, 5'b10000};
      6'd14: v = {3'd3, 5'b11100};
      6'd15: v = {3'd4, 5'b01100};
      6'd16: v = {3'd4, 5'b11010};
      6'd17: v = {3'd3, 5'b01000};
      6'd18: v = {3'd3, 5'b00000};
      6'd19: v = {3'd1, 5'b10000};
      6'd20: v = {3'd3, 5'b00100};
      6'd21: v = {3'd4, 5'b00010};
      6'd22: v = {3'd3, 5'b01100};
      6'd23: v = {3'd4, 5'b10010};
      6'd24: v = {3'd4, 5'b10110};
      6'd25: v = {3'd4, 5'b11000};
      6'd26: v = {3'd5, 5'b11111};
      6'd27: v = {3'd5, 5'b01111};
      6'd28: v = {3'd5, 5'b00111};
      6'd29: v = {3'd5, 5'b00011};
      6'd30: v = {3'd5, 5'b00001};
      6'd31: v = {3'd5, 5'b00000};
      6'd32: v = {3'd5, 5'b10000};
      6'd33: v = {3'd5, 5'b11000};
      6'd34: v = {3'd5, 5'b11100};
      6'd35: v = {3'd5, 5'b11110};
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  assign w_rom      = rom(char_code);
  assign w_dash     = r_pat[4];
  assign w_last     = (r_idx == r_len - 3'd1);
  assign w_mark_end = (r_cnt == (w_dash ? T3 : T1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_pat   <= '0;
      r_key   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (!en) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_idx   <= '0;
        r_key   <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_cnt <= '0;
            r_idx <= '0;
            if (start) begin
              if (char_code <= CODE_MAX) begin
                r_len   <= w_rom[7:5];
                r_pat   <= w_rom[4:0];
                r_state <= S_MARK;
                r_key   <= 1'b1;
                r_busy  <= 1'b1;
              end else if (char_code == CODE_WS) begin
                r_state <= S_WORD_GAP;
                r_busy  <= 1'b1;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          S_MARK: begin
            if (w_mark_end) begin
              r_cnt   <= '0;
              r_key   <= 1'b0;
              r_state <= w_last ? S_CHAR_GAP : S_GAP;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_GAP: begin
            if (r_cnt == T1) begin
              r_cnt   <= '0;
              r_idx   <= r_idx + 3'd1;
              r_pat   <= {r_pat[3:0], 1'b0};
              r_key   <= 1'b1;
              r_state <= S_MARK;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_CHAR_GAP: begin
            if (r_cnt == T3) begin
              r_cnt   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_WORD_GAP: begin
            if (r_cnt == T7) begin
              r_cnt   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_key   <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign key_out = r_key;
  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder with UNIT_CYCLES=4.
// Cycle c is the clock period following rising edge c-1; start is seen at edge 0.
module tb_morse_encoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       start;
  logic [5:0] char_code;
  logic       key_out;
  logic       busy;
  logic       done;
  logic       err;

  int checks;
  int errors;

  morse_encoder #(.UNIT_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .start     (start),
    .char_code (char_code),
    .key_out   (key_out),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    logic [3:0] got;
    rst_n = 1'b0;
    en = 1'b0;
    start = 1'b0;
    char_code = 6'd0;
    repeat (2) @(negedge clk);
    got = {key_out, busy, done, err};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL reset got %b want 0000", got);
    end
    rst_n = 1'b1;
    en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_e();
    logic [3:0] got;
    logic [3:0] exp;
    start = 1'b1;
    char_code = 6'd4;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      start = 1'b0;
      got = {key_out, busy, done, err};
      exp = {c <= 4, c <= 16, c == 17, 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL e c%0d got %b want %b", c, got, exp);
      end
    end
  endtask

  task automatic test_a();
    logic [3:0] got;
    logic [3:0] exp;
    start = 1'b1;
    char_code = 6'd0;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      start = 1'b0;
      got = {key_out, busy, done, err};
      exp = {(c <= 4) || (c >= 9 && c <= 20), c <= 32, c == 33, 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL a c%0d got %b want %b", c, got, exp);
      end
    end
  endtask

  task automatic test_word_and_invalid();
    logic [3:0] got;
    logic [3:0] exp;
    start = 1'b1;
    char_code = 6'd36;
    for (int c = 1; c <= 31; c++) begin
      @(negedge clk);
      start = 1'b0;
      got = {key_out, busy, done, err};
      exp = {1'b0, c <= 28, c == 29, 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL word c%0d got %b want %b", c, got, exp);
      end
    end
    start = 1'b1;
    char_code = 6'd40;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      got = {key_out, busy, done, err};
      exp = {3'b000, c == 1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL inval c%0d got %b want %b", c, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] got;
    logic [3:0] exp;
    start = 1'b1;
    char_code = 6'd19;
    for (int c = 1; c <= 44; c++) begin
      @(negedge clk);
      got = {key_out, busy, done, err};
      exp = {(c <= 12) || (c >= 26 && c <= 29),
             (c <= 24) || (c >= 26 && c <= 41),
             (c == 25) || (c == 42),
             1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL b2b c%0d got %b want %b", c, got, exp);
      end
      start = (c == 5) || (c >= 20 && c <= 25);
      char_code = (c >= 5) ? 6'd4 : 6'd19;
    end
    start = 1'b0;
  endtask

  task automatic test_en_abort();
    logic [3:0] got;
    logic [3:0] exp;
    start = 1'b1;
    char_code = 6'd26;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      got = {key_out, busy, done, err};
      exp = {c <= 6, c <= 6, 2'b00};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL en c%0d got %b want %b", c, got, exp);
      end
      if (c == 6)
        en = 1'b0;
    end
    start = 1'b1;
    char_code = 6'd4;
    @(negedge clk);
    got = {key_out, busy, done, err};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL en_block got %b want 0000", got);
    end
    start = 1'b0;
    en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [3:0] got;
    start = 1'b1;
    char_code = 6'd19;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    got = {key_out, busy, done, err};
    checks++;
    if (got !== 4'b1100) begin
      errors++;
      $display("FAIL pre_rst got %b want 1100", got);
    end
    #2 rst_n = 1'b0;
    #1 got = {key_out, busy, done, err};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL async_rst got %b want 0000", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      got = {key_out, busy, done, err};
      checks++;
      if (got !== 4'b0000) begin
        errors++;
        $display("FAIL post_rst c%0d got %b want 0000", c, got);
      end
    end
    test_e();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_e();
    test_a();
    test_word_and_invalid();
    test_back_to_back();
    test_en_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
